// File: rtl/uart_memif_arb.sv
// Round-robin arbiter sharing the UART register interface between two requesters,
// with an optional timed bus lock and routing of the one-cycle-delayed read response.
module uart_memif_arb #(
   parameter int LOCK_TIMEOUT = 16,
   parameter int AW = 4
) (
   input  logic          g_clk,
   input  logic          g_resetn,
   output logic          g_clk_req,
   input  logic          m0_req,
   output logic          m0_gnt,
   input  logic          m0_wen,
   input  logic [3:0]    m0_strb,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic          m0_lock,
   output logic          m0_rsp,
   output logic [31:0]   m0_rdata,
   output logic          m0_error,
   input  logic          m1_req,
   output logic          m1_gnt,
   input  logic          m1_wen,
   input  logic [3:0]    m1_strb,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_lock,
   output logic          m1_rsp,
   output logic [31:0]   m1_rdata,
   output logic          m1_error,
   output logic          s_req,
   input  logic          s_gnt,
   output logic          s_wen,
   output logic [3:0]    s_strb,
   output logic [AW-1:0] s_addr,
   output logic [31:0]   s_wdata,
   input  logic [31:0]   s_rdata,
   input  logic          s_error,
   output logic          lock_abort
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

   localparam logic [7:0] CNT_MAX = 8'(LOCK_TIMEOUT - 1);

   lock_state_t state, state_nxt;
   logic        last, last_nxt;
   logic        lock_owner, owner_nxt;
   logic [7:0]  lock_cnt, cnt_nxt;
   logic        rsp_pend, rsp_sel;
   logic        sel, sel_vld, sel_lock, acc, timeout;

   // While locked only the owner is eligible; otherwise round-robin on contention
   always_comb begin
      sel     = 1'b0;
      sel_vld = 1'b0;
      if (state == LOCKED) begin
         sel     = lock_owner;
         sel_vld = lock_owner ? m1_req : m0_req;
      end else if (m0_req && m1_req) begin
         sel     = ~last;
         sel_vld = 1'b1;
      end else if (m0_req) begin
         sel     = 1'b0;
         sel_vld = 1'b1;
      end else if (m1_req) begin
         sel     = 1'b1;
         sel_vld = 1'b1;
      end else begin
         sel     = 1'b0;
         sel_vld = 1'b0;
      end
   end

   assign s_req    = sel_vld;
   assign s_wen    = sel_vld && (sel ? m1_wen : m0_wen);
   assign s_strb   = sel_vld ? (sel ? m1_strb : m0_strb) : 4'b0;
   assign s_addr   = sel_vld ? (sel ? m1_addr : m0_addr) : {AW{1'b0}};
   assign s_wdata  = sel_vld ? (sel ? m1_wdata : m0_wdata) : 32'b0;
   assign sel_lock = sel ? m1_lock : m0_lock;

   assign acc        = sel_vld && s_gnt;
   assign m0_gnt     = acc && !sel;
   assign m1_gnt     = acc && sel;
   assign timeout    = (state == LOCKED) && (lock_cnt == CNT_MAX);
   assign lock_abort = timeout;

   assign m0_rsp   = rsp_pend && !rsp_sel;
   assign m1_rsp   = rsp_pend && rsp_sel;
   assign m0_rdata = m0_rsp ? s_rdata : 32'b0;
   assign m1_rdata = m1_rsp ? s_rdata : 32'b0;
   assign m0_error = m0_rsp && s_error;
   assign m1_error = m1_rsp && s_error;

   assign g_clk_req = m0_req || m1_req || rsp_pend || (state == LOCKED);

   // Lock state machine; any release hands priority away from the owner
   always_comb begin
      state_nxt = state;
      owner_nxt = lock_owner;
      cnt_nxt   = lock_cnt;
      last_nxt  = acc ? sel : last;
      case (state)
         UNLOCKED: begin
            if (acc && sel_lock) begin
               state_nxt = LOCKED;
               owner_nxt = sel;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = lock_cnt;
            end
         end
         LOCKED: begin
            // Timeout wins over the owner's lock bit on a coinciding transfer
            if (timeout || (acc && !sel_lock)) begin
               state_nxt = UNLOCKED;
               last_nxt  = lock_owner;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = lock_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = UNLOCKED;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state      <= UNLOCKED;
         last       <= 1'b1;
         lock_owner <= 1'b0;
         lock_cnt   <= 8'd0;
         rsp_pend   <= 1'b0;
         rsp_sel    <= 1'b0;
      end else begin
         state      <= state_nxt;
         last       <= last_nxt;
         lock_owner <= owner_nxt;
         lock_cnt   <= cnt_nxt;
         rsp_pend   <= acc;
         if (acc) begin
            rsp_sel <= sel;
         end else begin
            rsp_sel <= rsp_sel;
         end
      end
   end

endmodule

// File: doc/uart_memif_arb.md
Name: uart_memif_arb

Overview:
- Two-requester arbiter that shares the single UART register interface between a CPU-side port (m0) and a debug/monitor port (m1).
- Uses round-robin arbitration.
- Supports an optional bus lock so a requester can run an atomic sequence, e.g. poll STAT, then write TX.
- Routes the one-cycle-delayed read response back to the requester that was granted.
- Sits between the interconnect and the UART peripheral's memory interface, in the same clock domain.

Parameters:
- LOCK_TIMEOUT, 16: max consecutive cycles a lock may be held before forced release; legal range 2..255.
- AW, 4: address width forwarded to the UART; the low register-offset bits.

Ports:
- g_clk  in  1  gated clock
- g_resetn  in  1  synchronous active-low reset
- g_clk_req  out  1  clock request
- m0_req  in  1  requester 0 request
- m0_gnt  out  1  requester 0 grant
- m0_wen  in  1  requester 0 write enable
- m0_strb  in  4  requester 0 byte strobes
- m0_addr  in  AW  requester 0 address
- m0_wdata  in  32  requester 0 write data
- m0_lock  in  1  requester 0 lock request
- m0_rsp  out  1  requester 0 response valid
- m0_rdata  out  32  requester 0 read data
- m0_error  out  1  requester 0 error
- m1_*  same set and widths as m0_*  requester 1
- s_req  out  1  request to UART
- s_gnt  in  1  grant from UART
- s_wen  out  1  write enable to UART
- s_strb  out  4  byte strobes to UART
- s_addr  out  AW  address to UART
- s_wdata  out  32  write data to UART
- s_rdata  in  32  read data from UART
- s_error  in  1  error from UART
- lock_abort  out  1  one-cycle pulse on forced lock release

Behaviour:
- Clock is g_clk; reset is g_resetn, synchronous, active-low.
- Registered state:
  - last: last granted requester; reset 1, so m0 wins first contention.
  - locked, lock_owner, lock_cnt: all reset 0.
  - rsp_pend, rsp_sel: reset 0.
- Selection (combinational):
  - If locked: only lock_owner is eligible; the other requester's req is ignored.
  - Otherwise, a single requester is selected.
  - If both request, select !last.
  - If neither requests, s_req=0.
- Forwarding: s_req/s_wen/s_strb/s_addr/s_wdata are the selected requester's fields. When s_req=0, all forwarded fields are 0.
- Grant: mN_gnt = (sel==N) && mN_req && s_gnt. The non-selected gnt is 0.
- Accept: acc = s_req && s_gnt. On acc:
  - last <= sel
  - rsp_pend <= 1
  - rsp_sel <= sel
- When there is no acc, rsp_pend <= 0.
- Response, in the cycle after acc:
  - mN_rsp = rsp_pend && rsp_sel==N.
  - mN_rdata = s_rdata and mN_error = s_error when mN_rsp; otherwise both are 0.
  - Back-to-back accepts give back-to-back responses with no bubble.
- Lock state machine, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED: on acc with selected mN_lock=1; lock_owner <= sel, lock_cnt <= 0.
  - LOCKED, acc by owner with lock=0: -> UNLOCKED. That transfer completes normally.
  - LOCKED, otherwise: lock_cnt increments every cycle.
  - LOCKED, lock_cnt == LOCK_TIMEOUT-1: -> UNLOCKED and lock_abort=1 for that cycle. An owner transfer accepted in the same cycle completes, and the lock is released regardless of its lock bit.
  - Owner deasserting req does not release the lock; only the timeout does.
  - After any release, last = owner, so the other requester wins the next contention.
- g_clk_req = m0_req || m1_req || rsp_pend || locked.
- Reset mid-operation:
  - A pending response is dropped: mN_rsp=0 in the cycle after reset.
  - The lock is cleared and no lock_abort pulse is generated.
- Write-only transfers still produce mN_rsp, carrying s_error; rdata is whatever the UART drives, normally stale.

Test Plan:
- Single m0 read of addr 0x8 with s_rdata=0x0000_0005 -> m0_gnt same cycle; next cycle m0_rsp=1, m0_rdata=0x5, m1_rsp=0.
- Both requesting continuously for 4 cycles after reset -> grants m0,m1,m0,m1; each response routed to the matching port with the matching rdata.
- m1 locked write (m1_lock=1) then m0 requests for 5 cycles, then m1 write with lock=0 -> m0_gnt=0 throughout; after release, m0 granted next cycle.
- LOCK_TIMEOUT=4, m0 locks then idles -> lock_abort pulses exactly 4 cycles after the lock cycle; m1 is then granted.
- Owner transfer with lock=1 coinciding with the timeout cycle -> transfer accepted, response returned, lock_abort=1, lock released.
- Assert g_resetn=0 in the cycle after an accept -> no m*_rsp; all outputs 0; next contention grants m0.
